// File: rtl/elevator_car_ctrl_pkg.sv
// rtl/elevator_car_ctrl_pkg.sv - shared floor labels, state encoding and label/index helpers
package elevator_car_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic [1:0] LABEL_F1 = 2'b00;
  localparam logic [1:0] LABEL_F2 = 2'b01;
  localparam logic [1:0] LABEL_F3 = 2'b10;
  localparam logic [1:0] IDX_TOP  = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } goal_t;

  function automatic logic [1:0] idx_to_label(input logic [1:0] idx,
                                              input logic [1:0] l1, input logic [1:0] l2,
                                              input logic [1:0] l3);
    case (idx)
      2'd0:    return l1;
      2'd1:    return l2;
      default: return l3;
    endcase
  endfunction

  // Lowest floor wins if labels collide; a code matching no label is invalid.
  function automatic goal_t label_to_goal(input logic [1:0] code,
                                          input logic [1:0] l1, input logic [1:0] l2,
                                          input logic [1:0] l3);
    goal_t g;
    g.valid = 1'b1;
    if (code == l1)      g.idx = 2'd0;
    else if (code == l2) g.idx = 2'd1;
    else if (code == l3) g.idx = 2'd2;
    else begin
      g.valid = 1'b0;
      g.idx   = 2'd0;
    end
    return g;
  endfunction

  function automatic logic [2:0] floor_bit(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// rtl/elevator_car_ctrl_if.sv - goal/call inputs and car status outputs of the motion controller
interface elevator_car_ctrl_if;
  logic [1:0] gf;
  logic       led1, led2, led3;
  logic [1:0] floor;
  logic       moving, dir_up, door_open;
  logic       clr1, clr2, clr3;

  modport master (output gf, led1, led2, led3,
                  input  floor, moving, dir_up, door_open, clr1, clr2, clr3);
  modport slave  (input  gf, led1, led2, led3,
                  output floor, moving, dir_up, door_open, clr1, clr2, clr3);
endinterface

// File: rtl/elevator_car_ctrl_timer.sv
// rtl/elevator_car_ctrl_timer.sv - loadable down-counter, done while the count is zero
module elevator_car_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - three-floor car motion FSM with travel and door dwell timers
module elevator_car_ctrl
  import elevator_car_ctrl_pkg::*;
#(
  parameter logic [1:0] labelF1       = LABEL_F1,
  parameter logic [1:0] labelF2       = LABEL_F2,
  parameter logic [1:0] labelF3       = LABEL_F3,
  parameter int         TRAVEL_CYCLES = 4,
  parameter int         DOOR_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  elevator_car_ctrl_if.slave  bus
);
  localparam int TW = cnt_width(TRAVEL_CYCLES);
  localparam int DW = cnt_width(DOOR_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_idx, r_floor;
  logic       r_moving, r_dir_up, r_door_open;
  logic [2:0] r_clr;

  goal_t      w_goal;
  logic       w_act, w_step_blocked, w_trav_done, w_door_done;
  logic [1:0] w_next_idx;

  assign w_goal         = label_to_goal(bus.gf, labelF1, labelF2, labelF3);
  assign w_act          = (bus.led1 | bus.led2 | bus.led3) & w_goal.valid;
  assign w_step_blocked = r_dir_up ? (r_idx == IDX_TOP) : (r_idx == 2'd0);
  assign w_next_idx     = r_dir_up ? r_idx + 2'd1 : r_idx - 2'd1;

  // Timers hold their reload value while their state is inactive, so entry starts a full period.
  elevator_car_ctrl_timer #(.W(TW)) u_travel (
    .clk(clk), .reset(reset),
    .i_load((r_state != ST_MOVE) | w_trav_done), .i_load_val(TRAVEL_LOAD),
    .i_en(r_state == ST_MOVE), .o_done(w_trav_done)
  );

  elevator_car_ctrl_timer #(.W(DW)) u_door (
    .clk(clk), .reset(reset),
    .i_load(r_state != ST_DOOR), .i_load_val(DOOR_LOAD),
    .i_en(r_state == ST_DOOR), .o_done(w_door_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_floor     <= labelF1;
      r_moving    <= 1'b0;
      r_dir_up    <= 1'b1;
      r_door_open <= 1'b0;
      r_clr       <= 3'b000;
    end else begin
      r_clr <= 3'b000;
      case (r_state)
        ST_IDLE: begin
          if (w_act) begin
            if (w_goal.idx == r_idx) begin
              r_state     <= ST_DOOR;
              r_door_open <= 1'b1;
              r_clr       <= floor_bit(r_idx);
            end else begin
              r_state  <= ST_MOVE;
              r_moving <= 1'b1;
              r_dir_up <= (w_goal.idx > r_idx);
            end
          end
        end
        ST_MOVE: begin
          if (w_trav_done) begin
            if (w_step_blocked) begin
              r_state  <= ST_IDLE;
              r_moving <= 1'b0;
            end else begin
              r_idx   <= w_next_idx;
              r_floor <= idx_to_label(w_next_idx, labelF1, labelF2, labelF3);
              if (!w_act) begin
                r_state  <= ST_IDLE;
                r_moving <= 1'b0;
              end else if (w_goal.idx == w_next_idx) begin
                r_state     <= ST_DOOR;
                r_moving    <= 1'b0;
                r_door_open <= 1'b1;
                r_clr       <= floor_bit(w_next_idx);
              end else begin
                r_dir_up <= (w_goal.idx > w_next_idx);
              end
            end
          end
        end
        ST_DOOR: begin
          if (w_door_done) begin
            r_state     <= ST_IDLE;
            r_door_open <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.floor     = r_floor;
  assign bus.moving    = r_moving;
  assign bus.dir_up    = r_dir_up;
  assign bus.door_open = r_door_open;
  assign bus.clr1      = r_clr[0];
  assign bus.clr2      = r_clr[1];
  assign bus.clr3      = r_clr[2];
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - scoreboard bench: expected output-change events vs. monitored DUT
module tb_elevator_car_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_car_ctrl_if bus();

  elevator_car_ctrl dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] dt;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_chg = 0;
  bit  mon_en = 1'b0;
  logic [7:0] prev;

  localparam logic [7:0] RST_SNAP = {2'b00, 1'b0, 1'b1, 1'b0, 3'b000};

  function automatic logic [7:0] mk(input logic [1:0] f, input logic mv, input logic up,
                                    input logic door, input logic [2:0] clr);
    return {f, mv, up, door, clr};
  endfunction

  function automatic logic [7:0] snap();
    return {bus.floor, bus.moving, bus.dir_up, bus.door_open, bus.clr3, bus.clr2, bus.clr1};
  endfunction

  // Monitor: every change of the output vector is one event, checked with its spacing in cycles.
  initial begin
    logic [7:0] cur;
    ev_t e;
    int dt;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        cur = snap();
        if (cur !== prev) begin
          tests++;
          dt = cyc - last_chg;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change got=%b at cycle %0d", cur, cyc);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e.s || dt != int'(e.dt)) begin
              fails++;
              $display("FAIL event got=%b dt=%0d expected=%b dt=%0d", cur, dt, e.s, e.dt);
            end
          end
          last_chg = cyc;
          prev = cur;
        end
      end
    end
  end

  task automatic expect_ev(input logic [7:0] s, input int dt);
    ev_t e;
    e.s = s;
    e.dt = 8'(dt);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] g, input logic l1, input logic l2, input logic l3,
                       input bit mark);
    @(negedge clk);
    #2;
    bus.gf = g;
    bus.led1 = l1;
    bus.led2 = l2;
    bus.led3 = l3;
    if (mark) last_chg = cyc;
  endtask

  // Acts as the call latch: drop the served floor's led once its clear pulse is seen.
  task automatic wait_clr(input int fl);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (fl == 1 && bus.clr1) begin bus.led1 = 1'b0; seen = 1'b1; end
      if (fl == 2 && bus.clr2) begin bus.led2 = 1'b0; seen = 1'b1; end
      if (fl == 3 && bus.clr3) begin bus.led3 = 1'b0; seen = 1'b1; end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL clr%0d_timeout got=none expected=pulse", fl);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    bus.gf = 2'b00;
    bus.led1 = 1'b0;
    bus.led2 = 1'b0;
    bus.led3 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    s = snap();
    if (s !== RST_SNAP) begin
      fails++;
      $display("FAIL reset_state got=%b expected=%b", s, RST_SNAP);
    end
    #2;
    reset = 1'b0;
    prev = RST_SNAP;
    mon_en = 1'b1;

    // Same-floor call at floor 1
    expect_ev(mk(2'b00, 0, 1, 1, 3'b001), 1);
    expect_ev(mk(2'b00, 0, 1, 1, 3'b000), 1);
    expect_ev(mk(2'b00, 0, 1, 0, 3'b000), 2);
    drive(2'b00, 1, 0, 0, 1);
    wait_clr(1);
    wait_drain();

    // Floor 1 -> floor 3
    expect_ev(mk(2'b00, 1, 1, 0, 3'b000), 1);
    expect_ev(mk(2'b01, 1, 1, 0, 3'b000), 4);
    expect_ev(mk(2'b10, 0, 1, 1, 3'b100), 4);
    expect_ev(mk(2'b10, 0, 1, 1, 3'b000), 1);
    expect_ev(mk(2'b10, 0, 1, 0, 3'b000), 2);
    drive(2'b10, 0, 0, 1, 1);
    wait_clr(3);
    wait_drain();

    // Floor 3 -> floor 1
    expect_ev(mk(2'b10, 1, 0, 0, 3'b000), 1);
    expect_ev(mk(2'b01, 1, 0, 0, 3'b000), 4);
    expect_ev(mk(2'b00, 0, 0, 1, 3'b001), 4);
    expect_ev(mk(2'b00, 0, 0, 1, 3'b000), 1);
    expect_ev(mk(2'b00, 0, 0, 0, 3'b000), 2);
    drive(2'b00, 1, 0, 0, 1);
    wait_clr(1);
    wait_drain();

    // Goal retargeted to floor 2 before the first step
    expect_ev(mk(2'b00, 1, 1, 0, 3'b000), 1);
    expect_ev(mk(2'b01, 0, 1, 1, 3'b010), 4);
    expect_ev(mk(2'b01, 0, 1, 1, 3'b000), 1);
    expect_ev(mk(2'b01, 0, 1, 0, 3'b000), 2);
    drive(2'b10, 0, 0, 1, 1);
    drive(2'b01, 0, 1, 0, 0);
    wait_clr(2);
    wait_drain();

    // Request withdrawn mid-move: finish the step, stop with no door
    expect_ev(mk(2'b01, 1, 1, 0, 3'b000), 1);
    expect_ev(mk(2'b10, 0, 1, 0, 3'b000), 4);
    drive(2'b10, 0, 0, 1, 1);
    drive(2'b11, 0, 0, 0, 0);
    wait_drain();

    // Invalid goal code with a pending call is not actionable
    drive(2'b11, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    drive(2'b11, 0, 0, 0, 0);

    // Reset while the door is open at floor 2
    expect_ev(mk(2'b10, 1, 0, 0, 3'b000), 1);
    expect_ev(mk(2'b01, 0, 0, 1, 3'b010), 4);
    expect_ev(mk(2'b01, 0, 0, 1, 3'b000), 1);
    expect_ev(RST_SNAP, 1);
    drive(2'b01, 0, 1, 0, 1);
    wait_clr(2);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    tests++;
    s = snap();
    if (s !== RST_SNAP) begin
      fails++;
      $display("FAIL async_reset got=%b expected=%b", s, RST_SNAP);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wait_drain();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Car-motion controller for the three-floor elevator. It consumes the goal-floor code produced by the goal selector together with the pending-call LEDs. It drives the floor code and `moving` flag that the goal selector reads back, closing the loop. It also drives door control and per-floor request-clear pulses to the call latches. Motion is modelled with a per-floor travel counter and a door dwell counter.

## Interface
- `labelF1`, default 2'b00, code of floor 1 (lowest)
- `labelF2`, default 2'b01, code of floor 2
- `labelF3`, default 2'b10, code of floor 3 (highest)
- `TRAVEL_CYCLES`, default 4, clock cycles to move one floor (≥1)
- `DOOR_CYCLES`, default 3, clock cycles doors stay open (≥1)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `gf`  in  2  goal floor code from goal selector
- `led1`, `led2`, `led3`  in  1 each  pending call at floor 1/2/3
- `floor`  out  2  current floor code (one of the labels)
- `moving`  out  1  car between/leaving floors
- `dir_up`  out  1  direction of last/current motion, 1 = up
- `door_open`  out  1  doors open
- `clr1`, `clr2`, `clr3`  out  1 each  one-cycle clear pulse to the call latch of that floor

Clock and reset are one clock, asynchronous active-high reset (already decided).

## Operation
- Internal floor index `idx` 0..2; `floor` = label[idx]. `gf` is mapped to a goal index; any code matching no label (e.g. 2'b11 with defaults) is invalid.
- `any_req` = `led1|led2|led3`. A request is actionable only when `any_req`=1 and `gf` is valid.
- States:
  - IDLE: `moving`=0, `door_open`=0.
    - Actionable and goal == idx → DOOR; pulse `clr[idx]`.
    - Actionable and goal ≠ idx → MOVE; `dir_up` = (goal > idx); travel counter cleared.
    - Otherwise stay in IDLE.
  - MOVE: `moving`=1. The counter increments each cycle. On reaching TRAVEL_CYCLES-1, `idx` steps ±1 per `dir_up` and the counter clears. At that same edge the controller re-evaluates `gf`, using the value before the edge:
    - New idx == goal → DOOR; pulse `clr[new idx]`.
    - Goal valid and ≠ new idx → stay in MOVE; `dir_up` recomputed toward goal.
    - Goal invalid or `any_req`=0 → IDLE.
  - DOOR: `door_open`=1, `moving`=0. The dwell counter runs DOOR_CYCLES cycles, then the state returns to IDLE. Inputs are ignored in DOOR.
- `idx` saturates: it never steps below 0 or above 2. A step that would exceed the range is suppressed and the state goes to IDLE.

## Timing
- Reset values: state IDLE, `idx`=0 (`floor`=labelF1), `moving`=0, `dir_up`=1, `door_open`=0, `clr1..3`=0, all counters 0.
- Reset mid-MOVE or mid-DOOR takes effect immediately and asynchronously, returning to the values above. No clear pulse is issued.
- IDLE decision is registered: outputs change 1 cycle after an actionable request is sampled.
- One floor of travel = TRAVEL_CYCLES cycles from entering MOVE (or from the previous floor step) to the `floor` change.
- The `clr` pulse is asserted for exactly the cycle in which DOOR is first occupied, i.e. coincident with `door_open` rising.
- A same-floor call in IDLE gives `door_open` high for DOOR_CYCLES cycles. IDLE is re-entered, and a still-pending call is re-served only on the next IDLE evaluation.
- `floor` and `moving` are registered. The goal selector sees the stepped floor and `moving` in the same cycle.

## Structure
- Shared package/header `elevator_defs`: default floor labels, state encodings (IDLE, MOVE, DOOR), label↔index mapping functions. The goal selector uses the same defaults.
- Sub-module `elevator_timer`: a loadable down-counter with `done` output, instantiated twice (travel, door).

## Test plan
- Reset, then `gf`=00, `led1`=1 at floor 1 → 1 cycle later `door_open`=1 and `clr1`=1 for one cycle. `door_open` stays high 3 cycles, then IDLE; `moving` stays 0.
- From floor 1, `gf`=10, `led3`=1 → `moving`=1, `dir_up`=1. After 4 cycles `floor`=01; after 8 cycles `floor`=10, `door_open`=1, `clr3` pulse; `moving` is 0 after arrival.
- At floor 3, `gf`=00, `led1`=1 → `dir_up`=0, `floor` 10→01→00 at 4-cycle intervals, then DOOR with `clr1`.
- Mid-MOVE from floor 1 toward floor 3, change `gf` to 01 before the first step → stop at `floor`=01, DOOR with `clr2`.
- Mid-MOVE, drive `gf`=11 with leds low → car completes the current floor step, then IDLE, no door, no clear.
- Assert `reset` during DOOR at floor 2 → immediately `floor`=00, `door_open`=0, `moving`=0, no `clr` pulse.
